// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 keystream/decrypt engine and the key-search
// logic that reuses its plaintext checker.
package rc4_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    READ_SI   = 4'd1,
    WAIT_SI   = 4'd2,
    READ_SJ   = 4'd3,
    WAIT_SJ   = 4'd4,
    WR_I      = 4'd5,
    WR_J      = 4'd6,
    READ_F    = 4'd7,
    WAIT_F    = 4'd8,
    WRITE_OUT = 4'd9
  } state_t;

  localparam logic [7:0] CHAR_LO    = 8'h61;
  localparam logic [7:0] CHAR_HI    = 8'h7A;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

endpackage

// File: rtl/rc4_char_check.sv
// Combinational plaintext filter: a byte is acceptable when it is a lowercase
// ASCII letter or a space. A wrong key almost always fails this within a few
// bytes, so the key search can move on without finishing the message.
module rc4_char_check
  import rc4_pkg::*;
(
  input  logic [7:0] data_i,
  output logic       valid_o
);

  assign valid_o = ((data_i >= CHAR_LO) && (data_i <= CHAR_HI)) ||
                   (data_i == CHAR_SPACE);

endmodule

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA + decrypt. Walks the message one byte per 9-cycle pass: fetch S[i]
// and S[j], swap them in the S-box RAM, fetch S[S[i]+S[j]] alongside the
// ciphertext byte, then write the XOR into the plaintext RAM. All memories are
// synchronous-read, so every fetch has a dedicated wait state.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH   = 8,
  parameter int MSG_LEN     = 32,
  parameter int MSG_ADDR_W  = 5,
  parameter int CHECK_VALID = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  output logic                  done,
  output logic                  msg_valid,
  output logic [RAM_WIDTH-1:0]  s_addr,
  output logic [RAM_WIDTH-1:0]  s_wdata,
  output logic                  s_wren,
  input  logic [RAM_WIDTH-1:0]  s_rdata,
  output logic [MSG_ADDR_W-1:0] enc_addr,
  input  logic [RAM_WIDTH-1:0]  enc_rdata,
  output logic [MSG_ADDR_W-1:0] dec_addr,
  output logic [RAM_WIDTH-1:0]  dec_wdata,
  output logic                  dec_wren,
  output logic [3:0]            state_tap
);

  localparam logic [RAM_WIDTH-1:0]  ONE    = RAM_WIDTH'(1);
  localparam logic [MSG_ADDR_W-1:0] K_ONE  = MSG_ADDR_W'(1);
  localparam logic [MSG_ADDR_W-1:0] K_LAST = MSG_ADDR_W'(MSG_LEN - 1);

  state_t                state_q, state_d;
  logic [RAM_WIDTH-1:0]  i_q, i_d;
  logic [RAM_WIDTH-1:0]  j_q, j_d;
  logic [MSG_ADDR_W-1:0] k_q, k_d;
  logic [RAM_WIDTH-1:0]  si_q, si_d;
  logic [RAM_WIDTH-1:0]  sj_q, sj_d;
  logic [RAM_WIDTH-1:0]  f_q, f_d;
  logic [RAM_WIDTH-1:0]  e_q, e_d;
  logic                  done_q, done_d;
  logic                  msg_valid_q, msg_valid_d;

  logic [RAM_WIDTH-1:0]  plain;
  logic                  plain_ok;

  assign plain = f_q ^ e_q;

  rc4_char_check u_char_check (
    .data_i  (plain),
    .valid_o (plain_ok)
  );

  // Control state: FSM, indices and completion flags, cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      done_q      <= 1'b0;
      msg_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      done_q      <= done_d;
      msg_valid_q <= msg_valid_d;
    end
  end

  // Captured memory data; always loaded before use, so no reset needed.
  always_ff @(posedge clk) begin
    si_q <= si_d;
    sj_q <= sj_d;
    f_q  <= f_d;
    e_q  <= e_d;
  end

  // Next-state and memory-port decode; ports idle at zero outside their state.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    si_d        = si_q;
    sj_d        = sj_q;
    f_d         = f_q;
    e_d         = e_q;
    done_d      = done_q;
    msg_valid_d = msg_valid_q;
    s_addr      = '0;
    s_wdata     = '0;
    s_wren      = 1'b0;
    enc_addr    = '0;
    dec_addr    = '0;
    dec_wdata   = '0;
    dec_wren    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          done_d      = 1'b0;
          msg_valid_d = 1'b0;
          i_d         = '0;
          j_d         = '0;
          k_d         = '0;
          state_d     = READ_SI;
        end
      end
      READ_SI: begin
        i_d     = i_q + ONE;
        s_addr  = i_q + ONE;
        state_d = WAIT_SI;
      end
      WAIT_SI: begin
        si_d    = s_rdata;
        state_d = READ_SJ;
      end
      READ_SJ: begin
        j_d     = j_q + si_q;
        s_addr  = j_q + si_q;
        state_d = WAIT_SJ;
      end
      WAIT_SJ: begin
        sj_d    = s_rdata;
        state_d = WR_I;
      end
      // When i==j both writes land on the same entry with the same value.
      WR_I: begin
        s_addr  = i_q;
        s_wdata = sj_q;
        s_wren  = 1'b1;
        state_d = WR_J;
      end
      WR_J: begin
        s_addr  = j_q;
        s_wdata = si_q;
        s_wren  = 1'b1;
        state_d = READ_F;
      end
      // The swap does not change S[i]+S[j], so the pre-swap values index f.
      READ_F: begin
        s_addr   = si_q + sj_q;
        enc_addr = k_q;
        state_d  = WAIT_F;
      end
      WAIT_F: begin
        f_d     = s_rdata;
        e_d     = enc_rdata;
        state_d = WRITE_OUT;
      end
      // The byte is written even when it fails the check, then we stop early.
      WRITE_OUT: begin
        dec_addr  = k_q;
        dec_wdata = plain;
        dec_wren  = 1'b1;
        if ((CHECK_VALID != 0) && !plain_ok) begin
          done_d      = 1'b1;
          msg_valid_d = 1'b0;
          state_d     = IDLE;
        end else if (k_q == K_LAST) begin
          done_d      = 1'b1;
          msg_valid_d = 1'b1;
          state_d     = IDLE;
        end else begin
          k_d     = k_q + K_ONE;
          state_d = READ_SI;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done      = done_q;
  assign msg_valid = msg_valid_q;
  assign state_tap = state_q;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Directed bench for rc4_prga_decrypt: synchronous-read memory models around
// two instances (plaintext check on and off) and a reference RC4 model used to
// build ciphertext and the expected final S-box.
module tb_rc4_prga_decrypt;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_READ_SI = 4'd1;
  localparam logic [3:0] ST_WR_J    = 4'd6;

  logic       clk = 1'b0;
  logic       reset_n, start, start2, tb_load;

  logic       done, msg_valid, s_wren, dec_wren;
  logic [7:0] s_addr, s_wdata, s_rdata, enc_rdata, dec_wdata;
  logic [4:0] enc_addr, dec_addr;
  logic [3:0] state_tap;

  logic       done2, msg_valid2, s_wren2, dec_wren2;
  logic [7:0] s_addr2, s_wdata2, s_rdata2, enc_rdata2, dec_wdata2;
  logic [4:0] enc_addr2, dec_addr2;
  logic [3:0] state_tap2;

  logic [7:0] s_mem [256];
  logic [7:0] s_init [256];
  logic [7:0] s_mem2 [256];
  logic [7:0] enc_mem [32];
  logic [7:0] enc_mem2 [32];
  logic [7:0] dec_mem [32];
  logic [7:0] dec_mem2 [32];

  logic [7:0] gm_s [256];
  logic [7:0] ks [32];
  logic [7:0] pt [32];

  int s_wr_cnt, s_wr_bad, dec_wr_cnt, dec_wr_cnt2;
  int overlap = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rc4_prga_decrypt #(.RAM_WIDTH(8), .MSG_LEN(32), .MSG_ADDR_W(5), .CHECK_VALID(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .done(done), .msg_valid(msg_valid),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
    .enc_addr(enc_addr), .enc_rdata(enc_rdata), .dec_addr(dec_addr),
    .dec_wdata(dec_wdata), .dec_wren(dec_wren), .state_tap(state_tap)
  );

  rc4_prga_decrypt #(.RAM_WIDTH(8), .MSG_LEN(32), .MSG_ADDR_W(5), .CHECK_VALID(0)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .done(done2), .msg_valid(msg_valid2),
    .s_addr(s_addr2), .s_wdata(s_wdata2), .s_wren(s_wren2), .s_rdata(s_rdata2),
    .enc_addr(enc_addr2), .enc_rdata(enc_rdata2), .dec_addr(dec_addr2),
    .dec_wdata(dec_wdata2), .dec_wren(dec_wren2), .state_tap(state_tap2)
  );

  // Memory models and write monitors; tb_load reinitialises them between runs.
  always @(posedge clk) begin
    s_rdata    <= s_mem[s_addr];
    enc_rdata  <= enc_mem[enc_addr];
    s_rdata2   <= s_mem2[s_addr2];
    enc_rdata2 <= enc_mem2[enc_addr2];
    if (tb_load) begin
      s_mem <= s_init;
      for (int x = 0; x < 256; x++) s_mem2[x] <= 8'(x);
      for (int x = 0; x < 32; x++) begin
        dec_mem[x]  <= 8'hEE;
        dec_mem2[x] <= 8'hEE;
      end
      s_wr_cnt    <= 0;
      s_wr_bad    <= 0;
      dec_wr_cnt  <= 0;
      dec_wr_cnt2 <= 0;
    end else begin
      if (s_wren) begin
        s_mem[s_addr] <= s_wdata;
        s_wr_cnt      <= s_wr_cnt + 1;
        if (s_addr !== 8'h01 || s_wdata !== 8'h01) s_wr_bad <= s_wr_bad + 1;
      end
      if (dec_wren) begin
        dec_mem[dec_addr] <= dec_wdata;
        dec_wr_cnt        <= dec_wr_cnt + 1;
      end
      if (s_wren2) s_mem2[s_addr2] <= s_wdata2;
      if (dec_wren2) begin
        dec_mem2[dec_addr2] <= dec_wdata2;
        dec_wr_cnt2         <= dec_wr_cnt2 + 1;
      end
    end
    if ((s_wren && dec_wren) || (s_wren2 && dec_wren2)) overlap <= overlap + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic gm_identity();
    for (int x = 0; x < 256; x++) gm_s[x] = 8'(x);
  endtask

  task automatic gm_ksa(input logic [23:0] key);
    logic [7:0] j, t, kb;
    gm_identity();
    j = 8'h00;
    for (int x = 0; x < 256; x++) begin
      case (x % 3)
        0:       kb = key[23:16];
        1:       kb = key[15:8];
        default: kb = key[7:0];
      endcase
      j = j + gm_s[x] + kb;
      t = gm_s[x]; gm_s[x] = gm_s[j]; gm_s[j] = t;
    end
  endtask

  task automatic gm_prga();
    logic [7:0] i, j, t;
    i = 8'h00; j = 8'h00;
    for (int k = 0; k < 32; k++) begin
      i = i + 8'h01;
      j = j + gm_s[i];
      t = gm_s[i]; gm_s[i] = gm_s[j]; gm_s[j] = t;
      t = gm_s[i] + gm_s[j];
      ks[k] = gm_s[t];
    end
  endtask

  task automatic load_mems();
    tb_load = 1'b1;
    @(posedge clk); #1;
    tb_load = 1'b0;
  endtask

  // Key 24'h000249, plaintext "attack at dawn" padded with spaces.
  task automatic setup_attack();
    string str;
    str = "attack at dawn";
    gm_ksa(24'h000249);
    for (int x = 0; x < 256; x++) s_init[x] = gm_s[x];
    for (int x = 0; x < 32; x++) pt[x] = (x < str.len()) ? str[x] : 8'h20;
    gm_prga();
    for (int x = 0; x < 32; x++) enc_mem[x] = pt[x] ^ ks[x];
  endtask

  task automatic setup_all_a();
    gm_identity();
    for (int x = 0; x < 256; x++) s_init[x] = gm_s[x];
    gm_prga();
    for (int x = 0; x < 32; x++) enc_mem[x] = 8'h61 ^ ks[x];
  endtask

  // n = cycles from the accepting IDLE cycle (n=0) to the first cycle with done.
  task automatic run(input bit keep_start, output int n);
    start = 1'b1;
    n = 0;
    @(posedge clk); #1; n = 1;
    if (!keep_start) start = 1'b0;
    while (done !== 1'b1 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic check_attack(input string tag, input int n);
    int d;
    chk({tag, "_latency"}, n, 289);
    chk({tag, "_msg_valid"}, msg_valid, 1);
    for (int x = 0; x < 32; x++) chk($sformatf("%s_dec[%0d]", tag, x), dec_mem[x], pt[x]);
    d = 0;
    for (int x = 0; x < 256; x++) if (s_mem[x] !== gm_s[x]) d++;
    chk({tag, "_sbox_diffs"}, d, 0);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; start2 = 1'b0; tb_load = 1'b0;
    for (int x = 0; x < 32; x++) begin enc_mem[x] = 8'h00; enc_mem2[x] = 8'h00; end
    for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    repeat (2) @(posedge clk); #1;
    load_mems();

    // Reset state
    chk("rst_state", state_tap, ST_IDLE);
    chk("rst_state2", state_tap2, ST_IDLE);
    chk("rst_done", done, 0);
    chk("rst_msg_valid", msg_valid, 0);
    chk("rst_wren", {s_wren, dec_wren}, 0);
    chk("rst_addr", {s_addr, enc_addr, dec_addr}, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: identity S, zero ciphertext -> first byte 0x02 is rejected
    load_mems();
    run(1'b0, n);
    chk("t1_latency", n, 10);
    chk("t1_done", done, 1);
    chk("t1_msg_valid", msg_valid, 0);
    chk("t1_dec0", dec_mem[0], 8'h02);
    chk("t1_dec1_untouched", dec_mem[1], 8'hEE);
    chk("t1_dec_wr_cnt", dec_wr_cnt, 1);
    chk("t1_s_wr_cnt", s_wr_cnt, 2);
    chk("t1_s_wr_bad", s_wr_bad, 0);

    // 2: identity S, ciphertext chosen so plaintext is all 'a'
    setup_all_a();
    load_mems();
    chk("t2_enc0", enc_mem[0], 8'h63);
    run(1'b0, n);
    chk("t2_latency", n, 289);
    chk("t2_msg_valid", msg_valid, 1);
    chk("t2_dec_wr_cnt", dec_wr_cnt, 32);
    for (int x = 0; x < 32; x++) chk($sformatf("t2_dec[%0d]", x), dec_mem[x], 8'h61);

    // 3: KSA S-box, real message
    setup_attack();
    load_mems();
    run(1'b0, n);
    check_attack("t3", n);

    // 4: reset during WR_J of byte 5, then a clean rerun
    setup_attack();
    load_mems();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(dec_wr_cnt == 5 && state_tap == ST_WR_J) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("t4_reach_wr_j", state_tap, ST_WR_J);
    chk("t4_bytes_before", dec_wr_cnt, 5);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("t4_state", state_tap, ST_IDLE);
    chk("t4_done", done, 0);
    chk("t4_msg_valid", msg_valid, 0);
    chk("t4_wren", {s_wren, dec_wren}, 0);
    chk("t4_addr", {s_addr, enc_addr, dec_addr}, 0);
    setup_attack();
    load_mems();
    run(1'b0, n);
    check_attack("t4", n);

    // 5: start held high across a whole run
    setup_all_a();
    load_mems();
    run(1'b1, n);
    chk("t5_latency", n, 289);
    chk("t5_msg_valid", msg_valid, 1);
    chk("t5_dec_wr_cnt", dec_wr_cnt, 32);
    @(posedge clk); #1;
    chk("t5_restart_state", state_tap, ST_READ_SI);
    chk("t5_done_drop", done, 0);
    chk("t5_msg_valid_drop", msg_valid, 0);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("t5_second_done", done, 1);

    // 6: checker disabled, identity S, zero ciphertext
    load_mems();
    gm_identity();
    gm_prga();
    start2 = 1'b1;
    n = 0;
    @(posedge clk); #1; n = 1;
    start2 = 1'b0;
    while (done2 !== 1'b1 && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    chk("t6_latency", n, 289);
    chk("t6_msg_valid", msg_valid2, 1);
    chk("t6_dec_wr_cnt", dec_wr_cnt2, 32);
    chk("t6_dec0", dec_mem2[0], 8'h02);
    for (int x = 0; x < 32; x++) chk($sformatf("t6_dec[%0d]", x), dec_mem2[x], ks[x]);

    chk("one_wren_per_cycle", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
